uart_boot_loader: RTL

Byte-stream program loader sitting downstream of the UART receive controller. It consumes received-byte strobes and parses a framed image: magic byte, 16-bit word count, little-endian 32-bit words, and an optional XOR checksum. It writes each word into instruction memory through a single write port and holds the CPU in reset until an image has loaded successfully.

---
 rtl/uart_boot_loader.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART byte-stream image loader writing instruction memory (optional checksum: LOADER_CHECKSUM_EN)
module uart_boot_loader #(
    parameter int          ADDR_W    = 14,
    parameter int          BASE_ADDR = 0,
    parameter logic [23:0] TMO_MAX   = 24'd10_000_000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [7:0]        rx_data,
    input  logic              rx_vald,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [7:0]        MAGIC  = 8'hA5;
    localparam logic [ADDR_W-1:0] BASE_W = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA
`ifdef LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       count;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [23:0]       word_buf;
    logic [23:0]       tmo_cnt;

    logic              start;
    logic              fin_ok;
    logic              fin_err;
    logic              tmo_hit;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and frame-level events; a byte in the expiry cycle wins over timeout
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        fin_ok    = 1'b0;
        fin_err   = 1'b0;
        tmo_hit   = (state != S_IDLE) && !rx_vald && (tmo_cnt >= (TMO_MAX - 24'd1));
        case (state)
            S_IDLE: begin
                if (rx_vald && (rx_data == MAGIC)) begin
                    state_nxt = S_LEN_LO;
                    start     = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (rx_vald) begin
                    state_nxt = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_vald) begin
                    if ({rx_data, count[7:0]} != 16'd0) begin
                        state_nxt = S_DATA;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        state_nxt = S_CSUM;
`else
                        state_nxt = S_IDLE;
                        fin_ok    = 1'b1;
`endif
                    end
                end
            end
            S_DATA: begin
                if (rx_vald && (lane == 2'd3) && (count == 16'd1)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_IDLE;
                    fin_ok    = 1'b1;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (rx_vald) begin
                    state_nxt = S_IDLE;
                    if (rx_data == csum) begin
                        fin_ok  = 1'b1;
                    end else begin
                        fin_err = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (tmo_hit) begin
            state_nxt = S_IDLE;
            fin_err   = 1'b1;
        end
    end

    // Inter-byte timeout counter, only runs while a frame is open
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt <= 24'd0;
        end else if ((state == S_IDLE) || rx_vald) begin
            tmo_cnt <= 24'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
        end
    end

    // Word count capture and decrement as each word completes
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= 16'd0;
        end else if (rx_vald) begin
            if (state == S_LEN_LO) begin
                count[7:0] <= rx_data;
            end else if (state == S_LEN_HI) begin
                count[15:8] <= rx_data;
            end else if ((state == S_DATA) && (lane == 2'd3)) begin
                count <= count - 16'd1;
            end
        end
    end

    // Byte-lane assembly of little-endian words and the registered write port
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            word_idx  <= '0;
            lane      <= 2'd0;
            word_buf  <= 24'd0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                word_idx <= '0;
                lane     <= 2'd0;
            end else if ((state == S_DATA) && rx_vald) begin
                case (lane)
                    2'd0: word_buf[7:0]   <= rx_data;
                    2'd1: word_buf[15:8]  <= rx_data;
                    2'd2: word_buf[23:16] <= rx_data;
                    default: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE_W + word_idx;
                        mem_wdata <= {rx_data, word_buf};
                        word_idx  <= word_idx + ADDR_W'(1);
                    end
                endcase
                lane <= lane + 2'd1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over length and data bytes
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            csum <= 8'd0;
        end else if (start) begin
            csum <= 8'd0;
        end else if (rx_vald && ((state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA))) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    // Sticky status flags and CPU reset hold
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cpu_rst_n <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else if (start) begin
            cpu_rst_n <= 1'b0;
            load_busy <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else if (fin_ok) begin
            cpu_rst_n <= 1'b1;
            load_busy <= 1'b0;
            load_done <= 1'b1;
        end else if (fin_err) begin
            load_busy <= 1'b0;
            load_err  <= 1'b1;
        end
    end

endmodule
